// File: rtl/issue_scoreboard_if.sv
// Decode-to-scoreboard bundle: decoded instruction, hazard/flush/done inputs and
// the issue/stall decision with the registered pending bitmap.
interface issue_scoreboard_if #(
    parameter int NUM_REGS = 32,
    parameter int LAT_W    = 6
);
    logic                i_dec_valid;
    logic                i_dec_uses_rs;
    logic                i_dec_uses_rt;
    logic                i_dec_uses_rw;
    logic [4:0]          i_dec_rs_addr;
    logic [4:0]          i_dec_rt_addr;
    logic [4:0]          i_dec_rw_addr;
    logic                i_dec_is_fixed;
    logic [LAT_W-1:0]    i_dec_latency;
    logic                i_dec_is_var;
    logic                i_lw_hazard;
    logic                i_flush;
    logic                i_done_valid;
    logic [4:0]          i_done_addr;
    logic                o_issue;
    logic                o_stall;
    logic                o_unit_busy;
    logic [NUM_REGS-1:0] o_pending;

    // The decode stage drives the instruction and observes the decision.
    modport master (
        output i_dec_valid, i_dec_uses_rs, i_dec_uses_rt, i_dec_uses_rw,
               i_dec_rs_addr, i_dec_rt_addr, i_dec_rw_addr, i_dec_is_fixed,
               i_dec_latency, i_dec_is_var, i_lw_hazard, i_flush,
               i_done_valid, i_done_addr,
        input  o_issue, o_stall, o_unit_busy, o_pending
    );

    modport slave (
        input  i_dec_valid, i_dec_uses_rs, i_dec_uses_rt, i_dec_uses_rw,
               i_dec_rs_addr, i_dec_rt_addr, i_dec_rw_addr, i_dec_is_fixed,
               i_dec_latency, i_dec_is_var, i_lw_hazard, i_flush,
               i_done_valid, i_done_addr,
        output o_issue, o_stall, o_unit_busy, o_pending
    );
endinterface

// File: rtl/issue_scoreboard.sv
// Decode-stage issue controller: tracks registers owned by in-flight long-latency
// ops (shared mul/div unit and externally completed ops) and merges all hazards.
module issue_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int LAT_W    = 6
) (
    input  logic             clk,
    input  logic             rst,
    issue_scoreboard_if.slave sb
);

    typedef enum logic {
        IDLE,
        BUSY
    } unit_state_e;

    unit_state_e         state;
    logic [LAT_W-1:0]    cnt;
    logic [NUM_REGS-1:0] pending;
    logic [4:0]          fix_rw;
    logic                fix_valid;
    logic                unit_busy;

    logic                slot_live;
    logic                rw_tracked;
    logic                raw_hazard;
    logic                waw_hazard;
    logic                struct_hazard;
    logic                stall;
    logic                issue;
    logic                issue_fixed;
    logic                issue_var;
    logic                fix_retire;
    logic                done_clear;
    logic [LAT_W-1:0]    fix_load;
    logic [NUM_REGS-1:0] pending_next;

    // Hazards look only at registered state, so a clear landing this cycle
    // never unblocks a waiting instruction until the next cycle.
    assign slot_live     = sb.i_dec_valid && !sb.i_flush;
    assign rw_tracked    = sb.i_dec_uses_rw && (sb.i_dec_rw_addr != 5'd0);
    assign raw_hazard    = (sb.i_dec_uses_rs && pending[sb.i_dec_rs_addr]) ||
                           (sb.i_dec_uses_rt && pending[sb.i_dec_rt_addr]);
    assign waw_hazard    = rw_tracked && pending[sb.i_dec_rw_addr];
    assign struct_hazard = sb.i_dec_is_fixed && (state == BUSY);

    assign stall       = slot_live && (raw_hazard || waw_hazard || struct_hazard || sb.i_lw_hazard);
    assign issue       = slot_live && !stall;
    assign issue_fixed = issue && sb.i_dec_is_fixed;
    assign issue_var   = issue && sb.i_dec_is_var && !sb.i_dec_is_fixed;

    assign fix_load   = (sb.i_dec_latency == '0) ? LAT_W'(1) : sb.i_dec_latency;
    assign fix_retire = (state == BUSY) && (cnt == LAT_W'(1));
    assign done_clear = sb.i_done_valid && (sb.i_done_addr != 5'd0);

    // Clears are applied before the issue-set; a set to a register that is
    // being cleared cannot occur because such a write would have stalled on waw.
    always_comb begin
        pending_next = pending;
        if (fix_retire && fix_valid) begin
            pending_next[fix_rw] = 1'b0;
        end
        if (done_clear) begin
            pending_next[sb.i_done_addr] = 1'b0;
        end
        if ((issue_fixed || issue_var) && rw_tracked) begin
            pending_next[sb.i_dec_rw_addr] = 1'b1;
        end
    end

    // Mul/div unit occupancy: cnt holds the cycles left until the result is
    // forwardable; the owned destination is released on the final count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            pending   <= '0;
            fix_rw    <= 5'd0;
            fix_valid <= 1'b0;
            unit_busy <= 1'b0;
        end else begin
            pending <= pending_next;
            case (state)
                IDLE: begin
                    if (issue_fixed) begin
                        state     <= BUSY;
                        unit_busy <= 1'b1;
                        cnt       <= fix_load;
                        fix_rw    <= sb.i_dec_rw_addr;
                        fix_valid <= rw_tracked;
                    end
                end
                BUSY: begin
                    if (fix_retire) begin
                        state     <= IDLE;
                        unit_busy <= 1'b0;
                        cnt       <= '0;
                        fix_valid <= 1'b0;
                    end else begin
                        cnt <= cnt - LAT_W'(1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    unit_busy <= 1'b0;
                    cnt       <= '0;
                    fix_valid <= 1'b0;
                end
            endcase
        end
    end

    assign sb.o_stall     = stall;
    assign sb.o_issue     = issue;
    assign sb.o_unit_busy = unit_busy;
    assign sb.o_pending   = pending;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Scoreboard bench for issue_scoreboard: directed scenarios plus random traffic,
// predicted by an event-level register-ownership model and checked by a monitor.
module tb_issue_scoreboard;

    localparam int NUM_REGS = 32;
    localparam int LAT_W    = 6;

    typedef struct packed {
        bit       valid;
        bit       uses_rs;
        bit       uses_rt;
        bit       uses_rw;
        bit [4:0] rs;
        bit [4:0] rt;
        bit [4:0] rw;
        bit       is_fixed;
        bit [5:0] lat;
        bit       is_var;
        bit       lw;
        bit       flush;
        bit       done_valid;
        bit [4:0] done_addr;
    } stim_t;

    typedef struct {
        bit        stall;
        bit        issue;
        bit        busy;
        bit [31:0] pending;
        string     tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    issue_scoreboard_if #(.NUM_REGS(NUM_REGS), .LAT_W(LAT_W)) bus ();

    issue_scoreboard #(.NUM_REGS(NUM_REGS), .LAT_W(LAT_W)) dut (
        .clk (clk),
        .rst (rst),
        .sb  (bus.slave)
    );

    int        n_checks = 0;
    int        n_fail   = 0;
    exp_t      exp_q[$];

    // Reference model: a pending bit per register plus the edge index at which
    // the mul/div unit hands its result back.
    bit [31:0] m_pend      = '0;
    int        edge_num    = 0;
    int        fix_release = 0;
    bit        fix_owns    = 1'b0;
    bit [4:0]  fix_reg     = 5'd0;
    bit        last_issued = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    function automatic stim_t nop();
        stim_t s;
        s = '0;
        return s;
    endfunction

    task automatic driveInputs(input stim_t s);
        bus.i_dec_valid    = s.valid;
        bus.i_dec_uses_rs  = s.uses_rs;
        bus.i_dec_uses_rt  = s.uses_rt;
        bus.i_dec_uses_rw  = s.uses_rw;
        bus.i_dec_rs_addr  = s.rs;
        bus.i_dec_rt_addr  = s.rt;
        bus.i_dec_rw_addr  = s.rw;
        bus.i_dec_is_fixed = s.is_fixed;
        bus.i_dec_latency  = s.lat;
        bus.i_dec_is_var   = s.is_var;
        bus.i_lw_hazard    = s.lw;
        bus.i_flush        = s.flush;
        bus.i_done_valid   = s.done_valid;
        bus.i_done_addr    = s.done_addr;
    endtask

    function automatic exp_t predict(input stim_t s, input string tag);
        exp_t e;
        bit   busy;
        bit   blocked;
        bit   live;
        busy    = edge_num < fix_release;
        live    = s.valid && !s.flush;
        blocked = s.lw || (s.is_fixed && busy);
        if (s.uses_rs && m_pend[s.rs]) blocked = 1'b1;
        if (s.uses_rt && m_pend[s.rt]) blocked = 1'b1;
        if (s.uses_rw && s.rw != 5'd0 && m_pend[s.rw]) blocked = 1'b1;
        e.stall   = live && blocked;
        e.issue   = live && !blocked;
        e.busy    = busy;
        e.pending = m_pend;
        e.tag     = tag;
        return e;
    endfunction

    task automatic modelEdge(input stim_t s, input bit issued);
        int lat;
        edge_num++;
        if (fix_owns && edge_num == fix_release) m_pend[fix_reg] = 1'b0;
        if (s.done_valid && s.done_addr != 5'd0) m_pend[s.done_addr] = 1'b0;
        if (issued) begin
            if (s.is_fixed) begin
                lat         = (s.lat == 0) ? 1 : int'(s.lat);
                fix_release = edge_num + lat;
                fix_reg     = s.rw;
                fix_owns    = s.uses_rw && s.rw != 5'd0;
                if (fix_owns) m_pend[s.rw] = 1'b1;
            end else if (s.is_var && s.uses_rw && s.rw != 5'd0) begin
                m_pend[s.rw] = 1'b1;
            end
        end
    endtask

    task automatic applyStimulus(input stim_t s, input string tag);
        exp_t e;
        @(negedge clk);
        driveInputs(s);
        e = predict(s, tag);
        exp_q.push_back(e);
        last_issued = e.issue;
        @(posedge clk);
        modelEdge(s, e.issue);
    endtask

    task automatic presentUntilIssued(input stim_t s, input string tag, input int max_cycles);
        int n;
        n = 0;
        do begin
            applyStimulus(s, tag);
            n++;
        end while (!last_issued && n < max_cycles);
    endtask

    task automatic asyncResetMid();
        @(negedge clk);
        driveInputs(nop());
        #3;
        rst = 1'b1;
        #1;
        checkOutput("rst_mid.pending", bus.o_pending, 32'd0);
        checkOutput("rst_mid.busy", {31'd0, bus.o_unit_busy}, 32'd0);
        m_pend      = '0;
        fix_owns    = 1'b0;
        fix_release = edge_num;
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic stim_t randStim();
        stim_t s;
        s            = '0;
        s.valid      = $urandom_range(0, 9) < 8;
        s.uses_rs    = $urandom_range(0, 1) == 1;
        s.uses_rt    = $urandom_range(0, 1) == 1;
        s.uses_rw    = $urandom_range(0, 3) != 0;
        s.rs         = 5'($urandom_range(0, 7));
        s.rt         = 5'($urandom_range(0, 7));
        s.rw         = 5'($urandom_range(0, 7));
        s.is_fixed   = $urandom_range(0, 4) == 0;
        s.lat        = 6'($urandom_range(0, 6));
        s.is_var     = $urandom_range(0, 3) == 0;
        s.lw         = $urandom_range(0, 11) == 0;
        s.flush      = $urandom_range(0, 11) == 0;
        s.done_valid = $urandom_range(0, 2) == 0;
        s.done_addr  = 5'($urandom_range(0, 7));
        return s;
    endfunction

    // Monitor: compares every presented cycle against the queued prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput({e.tag, ".stall"}, {31'd0, bus.o_stall}, {31'd0, e.stall});
                checkOutput({e.tag, ".issue"}, {31'd0, bus.o_issue}, {31'd0, e.issue});
                checkOutput({e.tag, ".busy"}, {31'd0, bus.o_unit_busy}, {31'd0, e.busy});
                checkOutput({e.tag, ".pending"}, bus.o_pending, e.pending);
            end
        end
    end

    initial begin
        #300000;
        n_fail++;
        $display("[TB] FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        stim_t s;
        stim_t w;

        rst = 1'b1;
        driveInputs(nop());
        #2;
        checkOutput("reset.pending", bus.o_pending, 32'd0);
        checkOutput("reset.busy", {31'd0, bus.o_unit_busy}, 32'd0);
        checkOutput("reset.stall", {31'd0, bus.o_stall}, 32'd0);
        checkOutput("reset.issue", {31'd0, bus.o_issue}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Fixed mult r8, L=4, then a reader of r8 held until it issues.
        s = nop(); s.valid = 1; s.is_fixed = 1; s.uses_rw = 1; s.rw = 5'd8; s.lat = 6'd4;
        applyStimulus(s, "mul_r8");
        s = nop(); s.valid = 1; s.uses_rs = 1; s.rs = 5'd8; s.uses_rw = 1; s.rw = 5'd10;
        presentUntilIssued(s, "mul_dep", 10);
        applyStimulus(nop(), "mul_idle");

        // Back-to-back fixed ops: the second waits on the structural hazard.
        s = nop(); s.valid = 1; s.is_fixed = 1; s.uses_rw = 1; s.rw = 5'd11; s.lat = 6'd3;
        applyStimulus(s, "fix_a");
        s.rw = 5'd12; s.lat = 6'd2;
        presentUntilIssued(s, "fix_b", 10);
        repeat (3) applyStimulus(nop(), "fix_drain");

        // Variable-latency load r5; a writer of r5 waits for the done of r5 only.
        s = nop(); s.valid = 1; s.is_var = 1; s.uses_rw = 1; s.rw = 5'd5;
        applyStimulus(s, "var_r5");
        w = nop(); w.valid = 1; w.uses_rw = 1; w.rw = 5'd5;
        w.done_valid = 1; w.done_addr = 5'd6;
        applyStimulus(w, "waw_done6");
        w.done_valid = 0;
        applyStimulus(w, "waw_hold");
        w.done_valid = 1; w.done_addr = 5'd5;
        applyStimulus(w, "waw_done5");
        w.done_valid = 0;
        applyStimulus(w, "waw_issue");
        applyStimulus(nop(), "waw_idle");

        // Fixed r3 retires on the same edge that a done clears r9.
        s = nop(); s.valid = 1; s.is_var = 1; s.uses_rw = 1; s.rw = 5'd9;
        applyStimulus(s, "var_r9");
        s = nop(); s.valid = 1; s.is_fixed = 1; s.uses_rw = 1; s.rw = 5'd3; s.lat = 6'd2;
        applyStimulus(s, "fix_r3");
        applyStimulus(nop(), "fix_r3_wait");
        s = nop(); s.valid = 1; s.uses_rs = 1; s.rs = 5'd3; s.done_valid = 1; s.done_addr = 5'd9;
        applyStimulus(s, "dual_clear");
        s.done_valid = 0;
        applyStimulus(s, "dual_after");

        // r0 destination is never tracked; flush masks every hazard.
        s = nop(); s.valid = 1; s.is_fixed = 1; s.uses_rw = 1; s.rw = 5'd0; s.lat = 6'd3;
        applyStimulus(s, "fix_r0");
        s = nop(); s.valid = 1; s.uses_rs = 1; s.rs = 5'd0; s.uses_rt = 1; s.rt = 5'd0;
        applyStimulus(s, "read_r0");
        s = nop(); s.valid = 1; s.is_fixed = 1; s.lw = 1; s.flush = 1;
        applyStimulus(s, "flush_hazard");
        repeat (3) applyStimulus(nop(), "r0_drain");

        // Async reset in the middle of a long fixed op owning r4.
        s = nop(); s.valid = 1; s.is_fixed = 1; s.uses_rw = 1; s.rw = 5'd4; s.lat = 6'd20;
        applyStimulus(s, "fix_r4");
        applyStimulus(nop(), "fix_r4_busy");
        asyncResetMid();
        s = nop(); s.valid = 1; s.uses_rs = 1; s.rs = 5'd4; s.is_fixed = 1; s.lat = 6'd1;
        applyStimulus(s, "post_rst_read");
        applyStimulus(nop(), "post_rst_idle");

        for (int i = 0; i < 400; i++) begin
            applyStimulus(randStim(), "rand");
        end

        for (int r = 1; r < 8; r++) begin
            s = nop(); s.done_valid = 1; s.done_addr = 5'(r);
            applyStimulus(s, "drain");
        end

        repeat (2) @(negedge clk);
        #3;
        checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
